// File: rtl/isa_pkg.sv
// Shared constants for the 8-bit pipeline: interrupt sequencer state codes,
// injected-op codes, opcode values and the interrupt vector location.
package isa_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SAVE    = 3'd1;
    localparam logic [2:0] ST_VEC     = 3'd2;
    localparam logic [2:0] ST_ACTIVE  = 3'd3;
    localparam logic [2:0] ST_RET     = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;

    localparam logic [1:0] OP_NONE     = 2'd0;
    localparam logic [1:0] OP_PUSH_PC  = 2'd1;
    localparam logic [1:0] OP_LOAD_VEC = 2'd2;
    localparam logic [1:0] OP_POP_PC   = 2'd3;

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_RTI = 4'hB;

    // Data-memory word the memory side reads for a LOAD_VEC injection.
    localparam logic [7:0] VEC_ADDR_DEFAULT = 8'h01;

    function automatic logic at_boundary(input logic valid, input logic two_byte,
                                         input logic stall, input logic branch);
        return valid & ~two_byte & ~stall & ~branch;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Two-flop synchronizer for the external interrupt pin, plus a one-cycle
// pulse on each rising edge of the synchronized level.
module intr_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sync_r;

    // Shift the pin through two sync stages and keep one history bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], din};
        end
    end

    assign rise = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt entry/return sequencer: waits for a clean decode boundary, injects
// PC push / vector load / PC pop operations and redirects the fetch PC.
module intr_sequencer
    import isa_pkg::*;
#(
    parameter logic [3:0] RTI_OPCODE  = OPC_RTI,
    parameter int         MEM_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intr,
    input  logic [7:0] instr_id,
    input  logic [7:0] pc_id,
    input  logic       instr_valid,
    input  logic       two_byte_id,
    input  logic       stall_D_in,
    input  logic       branch_taken_ex,
    input  logic [7:0] mem_rdata,
    input  logic       mem_rvalid,
    output logic       stall_F,
    output logic       flush_F,
    output logic       flush_D,
    output logic [1:0] inject_op,
    output logic [7:0] ret_pc,
    output logic       pc_load,
    output logic [7:0] pc_target,
    output logic       save_flags,
    output logic       restore_flags,
    output logic       intr_ack,
    output logic       intr_active,
    output logic       intr_ret
);

    localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             pending_r;
    logic [7:0]       ret_pc_r;
    logic             edge_s;
    logic             boundary_s;
    logic             timeout_s;
    logic             unused_low_s;

    logic       stall_f_s, flush_f_s, flush_d_s, pc_load_s;
    logic       save_flags_s, restore_flags_s, intr_ack_s, intr_active_s, intr_ret_s;
    logic [1:0] inject_op_s;
    logic [7:0] pc_target_s;

    intr_sync_edge u_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (intr),
        .rise  (edge_s)
    );

    assign boundary_s   = at_boundary(instr_valid, two_byte_id, stall_D_in, branch_taken_ex);
    assign timeout_s    = (cnt_r == CNT_LIMIT) & ~mem_rvalid;
    assign unused_low_s = ^instr_id[3:0];

    // Next-state and control decode; memory response wins over a timeout
    always_comb begin
        state_nxt_s     = state_r;
        stall_f_s       = 1'b0;
        flush_f_s       = 1'b0;
        flush_d_s       = 1'b0;
        inject_op_s     = OP_NONE;
        pc_load_s       = 1'b0;
        pc_target_s     = 8'h00;
        save_flags_s    = 1'b0;
        restore_flags_s = 1'b0;
        intr_ack_s      = 1'b0;
        intr_active_s   = 1'b0;
        intr_ret_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r && boundary_s) begin
                    intr_ack_s  = 1'b1;
                    state_nxt_s = ST_SAVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SAVE: begin
                stall_f_s     = 1'b1;
                flush_f_s     = 1'b1;
                flush_d_s     = 1'b1;
                inject_op_s   = OP_PUSH_PC;
                save_flags_s  = 1'b1;
                intr_active_s = 1'b1;
                state_nxt_s   = ST_VEC;
            end
            ST_VEC: begin
                stall_f_s     = 1'b1;
                flush_f_s     = 1'b1;
                inject_op_s   = OP_LOAD_VEC;
                intr_active_s = 1'b1;
                if (mem_rvalid) begin
                    pc_load_s   = 1'b1;
                    pc_target_s = mem_rdata;
                    state_nxt_s = ST_ACTIVE;
                end else if (timeout_s) begin
                    pc_load_s   = 1'b1;
                    pc_target_s = ret_pc_r;
                    state_nxt_s = ST_RECOVER;
                end else begin
                    state_nxt_s = ST_VEC;
                end
            end
            ST_ACTIVE: begin
                intr_active_s = 1'b1;
                if (instr_valid && !stall_D_in && (instr_id[7:4] == RTI_OPCODE)) begin
                    state_nxt_s = ST_RET;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_RET: begin
                stall_f_s       = 1'b1;
                flush_f_s       = 1'b1;
                flush_d_s       = 1'b1;
                inject_op_s     = OP_POP_PC;
                restore_flags_s = (cnt_r == {CNT_W{1'b0}});
                intr_active_s   = 1'b1;
                if (mem_rvalid) begin
                    pc_load_s   = 1'b1;
                    pc_target_s = mem_rdata;
                    intr_ret_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (timeout_s) begin
                    pc_load_s   = 1'b1;
                    pc_target_s = ret_pc_r;
                    intr_ret_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RET;
                end
            end
            ST_RECOVER: begin
                intr_ret_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, wait counter, pending flag and return-PC capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            pending_r <= 1'b0;
            ret_pc_r  <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_VEC || state_r == ST_RET) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            // A new edge in the acknowledge cycle must not be lost
            if (edge_s) begin
                pending_r <= 1'b1;
            end else if (intr_ack_s) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
            if (intr_ack_s) begin
                ret_pc_r <= pc_id;
            end else begin
                ret_pc_r <= ret_pc_r;
            end
        end
    end

    assign stall_F       = stall_f_s;
    assign flush_F       = flush_f_s;
    assign flush_D       = flush_d_s;
    assign inject_op     = inject_op_s;
    assign ret_pc        = ret_pc_r;
    assign pc_load       = pc_load_s;
    assign pc_target     = pc_target_s;
    assign save_flags    = save_flags_s;
    assign restore_flags = restore_flags_s;
    assign intr_ack      = intr_ack_s;
    assign intr_active   = intr_active_s;
    assign intr_ret      = intr_ret_s;

endmodule

// File: tb/tb_intr_sequencer.sv
// Randomized bench for intr_sequencer, checked every cycle against a
// transaction-level model of interrupt entry, service and return.
module tb_intr_sequencer;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       intr;
    logic [7:0] instr_id;
    logic [7:0] pc_id;
    logic       instr_valid;
    logic       two_byte_id;
    logic       stall_D_in;
    logic       branch_taken_ex;
    logic [7:0] mem_rdata;
    logic       mem_rvalid;
    logic       stall_F, flush_F, flush_D, pc_load;
    logic [1:0] inject_op;
    logic [7:0] ret_pc, pc_target;
    logic       save_flags, restore_flags, intr_ack, intr_active, intr_ret;

    always #5 clk = ~clk;

    intr_sequencer #(.RTI_OPCODE(4'hB), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .intr(intr), .instr_id(instr_id), .pc_id(pc_id),
        .instr_valid(instr_valid), .two_byte_id(two_byte_id), .stall_D_in(stall_D_in),
        .branch_taken_ex(branch_taken_ex), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .stall_F(stall_F), .flush_F(flush_F), .flush_D(flush_D), .inject_op(inject_op),
        .ret_pc(ret_pc), .pc_load(pc_load), .pc_target(pc_target), .save_flags(save_flags),
        .restore_flags(restore_flags), .intr_ack(intr_ack), .intr_active(intr_active),
        .intr_ret(intr_ret)
    );

    logic [26:0] obs;
    assign obs = {stall_F, flush_F, flush_D, inject_op, ret_pc, pc_load, pc_target,
                  save_flags, restore_flags, intr_ack, intr_active, intr_ret};

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [26:0] got, input logic [26:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: where the interrupt handshake stands, plus pin history
    typedef enum int {P_WAIT_BOUNDARY, P_PUSH, P_FETCH_VEC, P_IN_ISR, P_POP, P_RECOVER} phase_t;
    phase_t     ph;
    int         waited;
    bit         pend;
    logic [7:0] saved_pc;
    bit         pin_seen [3];
    int         n_ack, n_tmo, n_rst;

    function automatic bit clean_boundary();
        return instr_valid && !two_byte_id && !stall_D_in && !branch_taken_ex;
    endfunction

    function automatic logic [26:0] model_out();
        logic       sf = 1'b0, ff = 1'b0, fd = 1'b0, ld = 1'b0, sv = 1'b0;
        logic       rs = 1'b0, ak = 1'b0, ac = 1'b0, rt = 1'b0;
        logic [1:0] op = 2'd0;
        logic [7:0] tg = 8'h00;
        case (ph)
            P_WAIT_BOUNDARY: ak = pend && clean_boundary();
            P_PUSH: begin
                sf = 1'b1; ff = 1'b1; fd = 1'b1; op = 2'd1; sv = 1'b1; ac = 1'b1;
            end
            P_FETCH_VEC: begin
                sf = 1'b1; ff = 1'b1; op = 2'd2; ac = 1'b1;
                if (mem_rvalid) begin
                    ld = 1'b1; tg = mem_rdata;
                end else if (waited == TMO) begin
                    ld = 1'b1; tg = saved_pc;
                end
            end
            P_IN_ISR: ac = 1'b1;
            P_POP: begin
                sf = 1'b1; ff = 1'b1; fd = 1'b1; op = 2'd3; ac = 1'b1;
                rs = (waited == 0);
                if (mem_rvalid) begin
                    ld = 1'b1; tg = mem_rdata; rt = 1'b1;
                end else if (waited == TMO) begin
                    ld = 1'b1; tg = saved_pc; rt = 1'b1;
                end
            end
            P_RECOVER: rt = 1'b1;
            default: ak = 1'b0;
        endcase
        return {sf, ff, fd, op, saved_pc, ld, tg, sv, rs, ak, ac, rt};
    endfunction

    task automatic model_reset();
        ph = P_WAIT_BOUNDARY;
        waited = 0;
        pend = 1'b0;
        saved_pc = 8'h00;
        for (int i = 0; i < 3; i++) pin_seen[i] = 1'b0;
    endtask

    task automatic model_advance();
        bit     rise;
        bit     ack;
        phase_t nxt;
        rise = pin_seen[1] && !pin_seen[2];
        ack  = (ph == P_WAIT_BOUNDARY) && pend && clean_boundary();
        nxt  = ph;
        if (ack) begin
            saved_pc = pc_id;
            n_ack++;
        end
        if (rise) pend = 1'b1;
        else if (ack) pend = 1'b0;
        case (ph)
            P_WAIT_BOUNDARY: if (ack) nxt = P_PUSH;
            P_PUSH:          nxt = P_FETCH_VEC;
            P_FETCH_VEC: begin
                if (mem_rvalid) nxt = P_IN_ISR;
                else if (waited == TMO) begin
                    nxt = P_RECOVER;
                    n_tmo++;
                end
            end
            P_IN_ISR: if (instr_valid && !stall_D_in && instr_id[7:4] == 4'hB) nxt = P_POP;
            P_POP: begin
                if (!mem_rvalid && waited == TMO) n_tmo++;
                if (mem_rvalid || waited == TMO) nxt = P_WAIT_BOUNDARY;
            end
            P_RECOVER: nxt = P_WAIT_BOUNDARY;
            default:   nxt = P_WAIT_BOUNDARY;
        endcase
        waited = (nxt != ph) ? 0 : waited + 1;
        ph = nxt;
        pin_seen[2] = pin_seen[1];
        pin_seen[1] = pin_seen[0];
        pin_seen[0] = intr;
    endtask

    initial begin
        n_ack = 0; n_tmo = 0; n_rst = 0;
        reset = 1'b0; intr = 1'b0; instr_id = 8'h00; pc_id = 8'h00;
        instr_valid = 1'b0; two_byte_id = 1'b0; stall_D_in = 1'b0; branch_taken_ex = 1'b0;
        mem_rdata = 8'h00; mem_rvalid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_state", obs, 27'd0);
        reset = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            reset = 1'b1;
            if ($urandom_range(0, 9) == 0) intr = ~intr;
            instr_valid     = ($urandom_range(0, 9) < 7);
            two_byte_id     = ($urandom_range(0, 9) < 2);
            stall_D_in      = ($urandom_range(0, 9) < 2);
            branch_taken_ex = ($urandom_range(0, 9) < 1);
            instr_id[7:4]   = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom_range(0, 15));
            instr_id[3:0]   = 4'($urandom_range(0, 15));
            pc_id           = 8'($urandom);
            mem_rdata       = 8'($urandom);
            mem_rvalid      = ($urandom_range(0, 99) < 35);
            #1;
            check_val("outs", obs, model_out());
            if (ph == P_FETCH_VEC && n_rst < 4 && $urandom_range(0, 5) == 0) begin
                // Async reset landing between clock edges while fetching the vector
                #2;
                reset = 1'b0;
                #1;
                check_val("async_reset", obs, 27'd0);
                model_reset();
                n_rst++;
            end else begin
                model_advance();
            end
        end

        $display("acks=%0d timeouts=%0d mid_resets=%0d", n_ack, n_tmo, n_rst);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_sequencer.md
Name: intr_sequencer

Overview:
- Sequences interrupt entry and return for the 8-bit pipeline; sits beside decode and drives its interrupt and flush controls.
- Entry: waits for a clean instruction boundary in decode, then flushes F/D. It then injects a PC+flags push and fetches the ISR vector from data memory. Finally it redirects the PC.
- Return: on RTI in decode, it injects a pop, restores flags, reloads PC and re-arms.
- Hazard logic outside this block owns ordinary stalls and forwarding.

Parameters:
- VEC_ADDR, 8'h01, data-memory address holding the ISR entry vector.
- RTI_OPCODE, 4'hB, value of instr_id[7:4] that identifies RTI.
- MEM_TIMEOUT, 4, max cycles to wait for mem_rvalid before forcing recovery.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- intr  in  1  external interrupt pin, asynchronous level.
- instr_id  in  8  instruction currently in decode.
- pc_id  in  8  PC of instr_id.
- instr_valid  in  1  decode holds a real (non-bubble) instruction.
- two_byte_id  in  1  instr_id consumes a following immediate byte.
- stall_D_in  in  1  hazard unit is stalling decode.
- branch_taken_ex  in  1  branch resolving taken in EX this cycle.
- mem_rdata  in  8  data-memory read data for injected ops.
- mem_rvalid  in  1  mem_rdata valid for the outstanding injected read.
- stall_F  out  1  hold fetch PC.
- flush_F  out  1  bubble IF/ID.
- flush_D  out  1  bubble ID/EX.
- inject_op  out  2  0 NONE, 1 PUSH_PC, 2 LOAD_VEC, 3 POP_PC.
- ret_pc  out  8  latched return PC, used as push data.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_target  out  8  redirect target.
- save_flags  out  1  snapshot CCR into the shadow register.
- restore_flags  out  1  restore CCR from the shadow register.
- intr_ack  out  1  one-cycle pulse at interrupt acceptance.
- intr_active  out  1  high from acceptance until return completes.
- intr_ret  out  1  one-cycle pulse when return completes.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, pending=0, ret_pc=0, timeout counter=0.
  - All outputs 0; inject_op=NONE.
- Pin input: intr is passed through a 2-flop synchronizer. A rising edge of the synchronized signal sets pending.
- pending clears on intr_ack. An edge arriving in the same cycle as intr_ack re-sets pending; the set has priority.
- Boundary condition: instr_valid & !two_byte_id & !stall_D_in & !branch_taken_ex.
- IDLE, with pending & boundary:
  - ret_pc<=pc_id, intr_ack=1 (combinational, that cycle).
  - Next state SAVE.
  - The instruction in decode is discarded and re-executes after return.
- IDLE otherwise: hold. All control outputs are 0.
- SAVE (exactly 1 cycle):
  - stall_F=1, flush_F=1, flush_D=1, inject_op=PUSH_PC, save_flags=1.
  - Next state VEC.
- VEC:
  - stall_F=1, flush_F=1, inject_op=LOAD_VEC (address VEC_ADDR); the counter increments.
  - On mem_rvalid: pc_load=1, pc_target=mem_rdata; next state ACTIVE.
  - On counter==MEM_TIMEOUT without mem_rvalid: pc_load=1, pc_target=ret_pc; next state RECOVER.
- ACTIVE:
  - intr_active=1. New edges set pending but are not serviced (no nesting).
  - On instr_valid & !stall_D_in & instr_id[7:4]==RTI_OPCODE: next state RET.
- RET:
  - stall_F=1, flush_F=1, flush_D=1, inject_op=POP_PC, restore_flags=1 (the latter only in the first RET cycle).
  - The counter runs as in VEC.
  - On mem_rvalid: pc_load=1, pc_target=mem_rdata, intr_ret=1; next state IDLE.
  - On timeout: pc_load=1, pc_target=ret_pc, intr_ret=1; next state IDLE.
- RECOVER (1 cycle):
  - intr_active=0, intr_ret=1.
  - Next state IDLE. The SP adjustment from the push is left to software.
- intr_active is high in SAVE, VEC, ACTIVE and RET.
- Interrupt pending at the end of RET/RECOVER is serviced at the first boundary in IDLE. This is no earlier than the cycle after intr_ret.
- The counter clears on every state change.
- pc_target=0 whenever pc_load=0.
- Reset mid-sequence aborts immediately to IDLE; no flags are restored.

Decomposition:
- Shared package (isa_pkg):
  - State encoding: IDLE, SAVE, VEC, ACTIVE, RET, RECOVER.
  - inject_op codes.
  - RTI and other opcode constants.
  - Default VEC_ADDR.
- One sub-module, intr_sync_edge: 2-flop synchronizer plus rising-edge pulse, async active-low reset.

Test Plan:
- Entry:
  - Stimulus: intr 0->1 with instr_valid=1, two_byte_id=0, pc_id=8'h24.
  - Response: after 2 sync cycles plus 1 cycle, intr_ack pulses and ret_pc=8'h24. Next cycle: SAVE with inject_op=1, flush_F/D=1, save_flags=1. mem_rvalid with mem_rdata=8'h80 gives pc_load=1, pc_target=8'h80, intr_active=1.
- Deferral:
  - Stimulus: pending while two_byte_id=1, then stall_D_in=1, then branch_taken_ex=1.
  - Response: no intr_ack during any of these. Ack arrives on the first cycle all three are 0.
- Return:
  - Stimulus: in ACTIVE, instr_id=8'hB0, instr_valid=1.
  - Response: next cycle inject_op=3 and restore_flags=1. mem_rvalid with 8'h24 gives pc_target=8'h24, intr_ret=1, intr_active=0.
- No nesting:
  - Stimulus: second intr edge during ACTIVE.
  - Response: no ack until after intr_ret. It is then acked at the next boundary, with one intr_ack per edge.
- Timeout:
  - Stimulus: in VEC, mem_rvalid held 0.
  - Response: after 4 cycles, pc_load=1 with pc_target=ret_pc, then intr_ret=1, then IDLE.
- Async reset:
  - Stimulus: reset=0 mid-VEC, between clock edges.
  - Response: all outputs 0 immediately and state=IDLE. A pending edge is lost.
